logic_gates: RTL and testbench

Registered two-input logic-gate unit: samples two single-bit operands `a` and `b` and drives six gate results (AND, NAND, OR, NOR, XOR, XNOR) from flip-flops. It is a leaf block that provides clean, glitch-free gate outputs to downstream logic. An optional input synchronizer allows it to accept asynchronous operands.

---
 rtl/logic_gates_if.sv | 35 +++
 rtl/logic_gates.sv | 80 ++++++++
 tb/tb_logic_gates.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/logic_gates_if.sv
// logic_gates_if: groups the operand inputs and the six registered gate
// results of logic_gates so they travel as a single bundle.
// master drives the operands and observes the results; slave is the gate unit.
interface logic_gates_if;
   logic a;
   logic b;
   logic y0;
   logic y1;
   logic y2;
   logic y3;
   logic y4;
   logic y5;

   modport master (
      output a,
      output b,
      input  y0,
      input  y1,
      input  y2,
      input  y3,
      input  y4,
      input  y5
   );

   modport slave (
      input  a,
      input  b,
      output y0,
      output y1,
      output y2,
      output y3,
      output y4,
      output y5
   );
endinterface : logic_gates_if

// File: rtl/logic_gates.sv
// logic_gates: registered two-input gate unit. It samples operands a and b
// and drives AND, NAND, OR, NOR, XOR and XNOR results from flip-flops.
// Optional macro LOGIC_GATES_INPUT_SYNC_EN inserts a two-flop synchronizer
// on each operand, so asynchronous operands are accepted; latency then grows
// from 1 to 3 cycles. Function, reset values and invariants do not change.
module logic_gates (
   input  logic          clk,
   input  logic          reset,
   logic_gates_if.slave  gates
);

   // Sampled operand pair seen by the combinational core.
   logic w_a_s;
   logic w_b_s;

`ifdef LOGIC_GATES_INPUT_SYNC_EN
   // Two stages per operand; the first stage may go metastable, the second
   // gives it a full cycle to resolve before the core uses it.
   logic r_a_meta;
   logic r_a_sync;
   logic r_b_meta;
   logic r_b_sync;

   // Operand synchronizer chains, cleared to 0 by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a_meta <= 1'b0;
         r_a_sync <= 1'b0;
         r_b_meta <= 1'b0;
         r_b_sync <= 1'b0;
      end else begin
         r_a_meta <= gates.a;
         r_a_sync <= r_a_meta;
         r_b_meta <= gates.b;
         r_b_sync <= r_b_meta;
      end
   end

   assign w_a_s = r_a_sync;
   assign w_b_s = r_b_sync;
`else
   // Operands are assumed synchronous to clk and are used directly.
   assign w_a_s = gates.a;
   assign w_b_s = gates.b;
`endif

   // Bit k of the vectors below corresponds to output yk.
   logic [5:0] w_y_next;
   logic [5:0] r_y;

   // Combinational core: all six functions from one operand pair, so both
   // operands are always taken from the same edge.
   always_comb begin
      w_y_next    = 6'b10_1010;
      w_y_next[0] = w_a_s & w_b_s;
      w_y_next[1] = ~(w_a_s & w_b_s);
      w_y_next[2] = w_a_s | w_b_s;
      w_y_next[3] = ~(w_a_s | w_b_s);
      w_y_next[4] = w_a_s ^ w_b_s;
      w_y_next[5] = ~(w_a_s ^ w_b_s);
   end

   // Output register, loaded every cycle; reset value equals the a=b=0 result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_y <= 6'b10_1010;
      end else begin
         r_y <= w_y_next;
      end
   end

   // Outputs come only from flops: no combinational input-to-output path.
   assign gates.y0 = r_y[0];
   assign gates.y1 = r_y[1];
   assign gates.y2 = r_y[2];
   assign gates.y3 = r_y[3];
   assign gates.y4 = r_y[4];
   assign gates.y5 = r_y[5];

endmodule : logic_gates

// File: tb/tb_logic_gates.sv
// tb_logic_gates: self-checking bench for logic_gates. A delay-line model of
// operand pairs, evaluated with plain arithmetic, is compared against the DUT
// on every falling edge; directed steps add literal expectations.
`timescale 1ns/1ps
module tb_logic_gates;

`ifdef LOGIC_GATES_INPUT_SYNC_EN
   localparam int DEPTH = 3;
`else
   localparam int DEPTH = 1;
`endif

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   logic_gates_if u_if ();

   logic_gates u_dut (
      .clk   (clk),
      .reset (reset),
      .gates (u_if)
   );

   wire [5:0] y = {u_if.y5, u_if.y4, u_if.y3, u_if.y2, u_if.y1, u_if.y0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: y5..y0 from the count of ones among the operands.
   function automatic logic [5:0] gates_of(input logic [1:0] p);
      int s;
      logic [5:0] r;
      s    = int'(p[1]) + int'(p[0]);
      r[0] = (s == 2);
      r[2] = (s >= 1);
      r[4] = (s == 1);
      r[1] = !r[0];
      r[3] = !r[2];
      r[5] = !r[4];
      return r;
   endfunction

   // Operand pairs captured on recent edges; index DEPTH-1 is what the outputs show.
   logic [1:0] pipe [DEPTH];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) pipe[i] <= 2'b00;
      end else begin
         pipe[0] <= {u_if.a, u_if.b};
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   task automatic check6(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got y5..y0=%b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model plus structural invariants.
   always @(negedge clk) begin
      check6("model", y, gates_of(pipe[DEPTH-1]));
      check1("pair_nand", y[1], ~y[0]);
      check1("pair_nor", y[3], ~y[2]);
      check1("pair_xnor", y[5], ~y[4]);
      check1("and_implies_or", (~y[0]) | y[2], 1'b1);
      check1("xor_eq_or_nand", y[4], y[2] & y[1]);
      check1("onehot_and_nor_xor", (int'(y[0]) + int'(y[3]) + int'(y[4])) == 1, 1'b1);
   end

   // Change operands 2 ns after a rising edge.
   task automatic drive(input logic a, input logic b);
      @(posedge clk);
      #2;
      u_if.a = a;
      u_if.b = b;
   endtask

   task automatic settle();
      repeat (DEPTH) @(posedge clk);
      #1;
   endtask

   logic [5:0] samp [6];
   logic [1:0] seq_ops [3];

   initial begin
      checks   = 0;
      failures = 0;
      u_if.a   = 1'b1;
      u_if.b   = 1'b1;
      reset    = 1'b1;
      #1;
      // Model pinned to hand-computed truth-table rows.
      check6("model_00", gates_of(2'b00), 6'b101010);
      check6("model_11", gates_of(2'b11), 6'b100101);
      check6("reset_immediate", y, 6'b101010);
      repeat (3) @(posedge clk);
      #1;
      check6("reset_held", y, 6'b101010);
      @(negedge clk);
      reset = 1'b0;

      // Truth table with settle.
      drive(1'b0, 1'b0); settle(); check6("tt_00", y, 6'b101010);
      drive(1'b1, 1'b0); settle(); check6("tt_10", y, 6'b010110);
      drive(1'b0, 1'b1); settle(); check6("tt_01", y, 6'b010110);
      drive(1'b1, 1'b1); settle(); check6("tt_11", y, 6'b100101);

      // Latency: y0 must rise exactly DEPTH edges after the change.
      drive(1'b0, 1'b0); settle();
      drive(1'b1, 1'b1);
      #1;
      check1("latency_early", u_if.y0, 1'b0);
      repeat (DEPTH - 1) begin
         @(posedge clk); #1;
         check1("latency_early", u_if.y0, 1'b0);
      end
      @(posedge clk); #1;
      check1("latency_edge", u_if.y0, 1'b1);

      // Back-to-back operands on consecutive cycles.
      seq_ops[0] = 2'b10;
      seq_ops[1] = 2'b11;
      seq_ops[2] = 2'b00;
      drive(seq_ops[0][1], seq_ops[0][0]);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         samp[k] = y;
         #1;
         if (k < 2) begin
            u_if.a = seq_ops[k+1][1];
            u_if.b = seq_ops[k+1][0];
         end
      end
      check1("b2b_y4_0", samp[DEPTH-1][4], 1'b1);
      check1("b2b_y4_1", samp[DEPTH][4],   1'b0);
      check1("b2b_y4_2", samp[DEPTH+1][4], 1'b0);
      check1("b2b_y0_0", samp[DEPTH-1][0], 1'b0);
      check1("b2b_y0_1", samp[DEPTH][0],   1'b1);
      check1("b2b_y0_2", samp[DEPTH+1][0], 1'b0);

      // Mid-operation asynchronous reset.
      drive(1'b1, 1'b1); settle();
      check6("pre_reset_11", y, 6'b100101);
      #2;
      reset = 1'b1;
      #1;
      check6("midreset_async", y, 6'b101010);
      u_if.a = 1'b0;
      @(posedge clk); #2;
      u_if.a = 1'b1;
      @(posedge clk); #1;
      check6("midreset_held", y, 6'b101010);
      @(negedge clk);
      reset = 1'b0;
      settle();
      check6("after_release", y, 6'b100101);

      // Random operands with occasional asynchronous resets.
      for (int n = 0; n < 1000; n++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 99) == 0) begin
            #1;
            reset = 1'b1;
            #4;
            reset = 1'b0;
         end
      end
      repeat (DEPTH + 1) @(posedge clk);
      @(negedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_logic_gates
